mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported, variable-latency memory between the processor's fetch port
//  (pc/inst) and data port (address/write_data/wmask/wen). Data access wins ties (older
//  M-stage op). One transaction in flight at a time; requesters hold requests until a
//  1-cycle ack. Watchdog flags a memory that never answers.
// PARAMETERS
//  ADDR_W      32   address width
//  DATA_W      32   data width; wmask width is DATA_W/8
//  TIMEOUT     255  max cycles in REQ or RESP before err is set (>=1)
// PORTS
//  clk         in   1         clock, rising edge
//  reset       in   1         asynchronous, active-low reset
//  i_req       in   1         fetch request, held until i_ack
//  i_addr      in   ADDR_W    fetch address (pc)
//  i_ack       out  1         1-cycle pulse: i_rdata valid
//  i_rdata     out  DATA_W    fetched instruction, held until next fetch ack
//  d_req       in   1         data request, held until d_ack
//  d_we        in   1         1=store, 0=load
//  d_addr      in   ADDR_W    data address
//  d_wdata     in   DATA_W    store data
//  d_wmask     in   DATA_W/8  store byte mask
//  d_ack       out  1         1-cycle pulse: store accepted / d_rdata valid
//  d_rdata     out  DATA_W    load data, held until next load ack
//  mem_req     out  1         memory request valid
//  mem_we      out  1         memory write enable
//  mem_addr    out  ADDR_W    memory address
//  mem_wdata   out  DATA_W    memory write data
//  mem_wmask   out  DATA_W/8  memory byte mask (0 on reads)
//  mem_ready   in   1         memory accepts request this cycle (mem_req && mem_ready)
//  mem_rvalid  in   1         read data valid (reads only; ignored outside RESP)
//  mem_rdata   in   DATA_W    read data
//  busy        out  1         state != IDLE
//  err         out  1         sticky watchdog error; cleared only by reset
// BEHAVIOUR
//  Reset (reset==0, async): state=IDLE, owner=FETCH, counter=0; all outputs 0.
//  States: IDLE, REQ, RESP. Registered: owner, latched addr/we/wdata/wmask, rdata regs.
//  IDLE: if d_req -> latch data op, owner=DATA, REQ; else if i_req -> latch fetch
//    (we=0, wmask=0), owner=FETCH, REQ; else stay. Grant costs one cycle.
//  REQ: mem_req=1, mem_* driven from latched regs (stable until accepted).
//    mem_ready && we -> d_ack=1 next cycle, state IDLE.
//    mem_ready && !we -> RESP. mem_rvalid in same cycle as acceptance is ignored.
//  RESP: mem_req=0; on mem_rvalid capture mem_rdata into i_rdata or d_rdata per owner,
//    pulse matching ack next cycle (registered), state IDLE.
//  Acks are registered: ack asserted the cycle after the completing handshake, while
//    state is already IDLE. In the ack cycle the acked requester's req is not
//    re-sampled (no double grant); the other requester may be granted.
//  Latency, no contention, mem_ready=1, 1-cycle read: req@0 -> grant@1 (REQ),
//    accept@1 -> RESP@2 -> rvalid@2 -> ack@3.
//  Starvation: data priority is fixed; fetch waits while d_req is asserted back to back.
//  Watchdog: counter clears on every state change, increments each cycle in REQ/RESP;
//    reaching TIMEOUT sets err=1, forces IDLE, no ack is issued; the requester stays
//    pending and is re-granted per the IDLE rules.
//  Requests dropped before ack: undefined by protocol; the arbiter completes the latched
//    transaction regardless.
//  reset asserted mid-transaction: everything aborts immediately to reset values; the
//    memory sees mem_req fall without acceptance.
// TESTING
//  1 Fetch only: i_req=1, i_addr=0x100, mem_ready=1, rvalid 1 cycle later with 0x00000013
//    -> mem_addr=0x100, mem_we=0; i_ack pulse at cycle 3; i_rdata=0x13.
//  2 Simultaneous: i_req=d_req=1, d_we=1, d_addr=0x2000, d_wmask=4'b0011
//    -> store issued first with mem_wmask=0011, d_ack; then fetch issued; no mem_req gap
//       beyond one IDLE cycle.
//  3 Back-pressure: mem_ready low 5 cycles during a load -> mem_addr/mem_we/mem_wdata
//    stable all 5 cycles; single d_ack after rvalid; d_rdata=mem_rdata.
//  4 Watchdog: TIMEOUT=4, mem_ready=1, mem_rvalid never -> err=1 after 4 RESP cycles,
//    busy=0, no ack; err stays 1 until reset.
//  5 Async reset mid-RESP: reset=0 between clock edges -> mem_req/busy/acks 0 immediately;
//    after release first grant follows IDLE priority.
//  6 Random: constrained-random req/ready/rvalid latencies vs reference model; check at
//    most one outstanding request, one ack per request, correct data routing.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported, variable-latency memory between the fetch and data ports,
// data wins ties, one transaction in flight, 1-cycle registered acks, sticky watchdog error.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_ack,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wmask,
  output logic                d_ack,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_ready,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy,
  output logic                err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  state_t              r_state;
  logic                r_own_d;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W/8-1:0] r_wmask;
  logic [CW-1:0]       r_cnt;
  logic                r_i_ack;
  logic                r_d_ack;
  logic [DATA_W-1:0]   r_i_rdata;
  logic [DATA_W-1:0]   r_d_rdata;
  logic                r_err;
  logic                w_d_go;
  logic                w_i_go;
  logic                w_to;
  // a requester is not re-sampled in its own ack cycle, so a held req cannot be granted twice
  assign w_d_go = d_req && !r_d_ack;
  assign w_i_go = i_req && !r_i_ack;
  assign w_to   = r_cnt == CW'(TIMEOUT - 1);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_own_d   <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wmask   <= '0;
      r_cnt     <= '0;
      r_i_ack   <= 1'b0;
      r_d_ack   <= 1'b0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
      r_err     <= 1'b0;
    end else begin
      r_i_ack <= 1'b0;
      r_d_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (w_d_go) begin
            r_state <= REQ;
            r_own_d <= 1'b1;
            r_we    <= d_we;
            r_addr  <= d_addr;
            r_wdata <= d_wdata;
            r_wmask <= d_we ? d_wmask : '0;
          end else if (w_i_go) begin
            r_state <= REQ;
            r_own_d <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= i_addr;
            r_wdata <= '0;
            r_wmask <= '0;
          end
        end
        REQ: begin
          if (mem_ready) begin
            r_state <= r_we ? IDLE : RESP;
            r_d_ack <= r_we;
            r_cnt   <= '0;
          end else if (w_to) begin
            r_state <= IDLE;
            r_err   <= 1'b1;
            r_cnt   <= '0;
          end else r_cnt <= r_cnt + 1'b1;
        end
        RESP: begin
          if (mem_rvalid) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            if (r_own_d) begin
              r_d_rdata <= mem_rdata;
              r_d_ack   <= 1'b1;
            end else begin
              r_i_rdata <= mem_rdata;
              r_i_ack   <= 1'b1;
            end
          end else if (w_to) begin
            r_state <= IDLE;
            r_err   <= 1'b1;
            r_cnt   <= '0;
          end else r_cnt <= r_cnt + 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign mem_req   = r_state == REQ;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_wmask = r_wmask;
  assign busy      = r_state != IDLE;
  assign err       = r_err;
  assign i_ack     = r_i_ack;
  assign d_ack     = r_d_ack;
  assign i_rdata   = r_i_rdata;
  assign d_rdata   = r_d_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table, directed corner sequences and a random run against a transaction-level memory/requester model.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_req, d_req, d_we, mem_ready, mem_rvalid;
  logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic [3:0]  d_wmask;
  logic        i_ack, d_ack, mem_req, mem_we, busy, err;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        w1_i_ack, w1_d_ack, w1_mem_req, w1_mem_we, w1_busy, w1_err;
  logic [31:0] w1_i_rdata, w1_d_rdata, w1_mem_addr, w1_mem_wdata;
  logic [3:0]  w1_mem_wmask;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) u0 (
    .clk(clk), .reset(reset), .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
    .d_ack(d_ack), .d_rdata(d_rdata), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .busy(busy), .err(err));

  // short-timeout copy sharing all inputs, used for the watchdog sequence
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) u1 (
    .clk(clk), .reset(reset), .i_req(i_req), .i_addr(i_addr), .i_ack(w1_i_ack), .i_rdata(w1_i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
    .d_ack(w1_d_ack), .d_rdata(w1_d_rdata), .mem_req(w1_mem_req), .mem_we(w1_mem_we),
    .mem_addr(w1_mem_addr), .mem_wdata(w1_mem_wdata), .mem_wmask(w1_mem_wmask),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .busy(w1_busy), .err(w1_err));

  typedef struct {
    logic ir, dr, dw;
    logic [3:0] wm;
    logic er, ew;
    logic [31:0] ea;
    logic [3:0] ewm;
  } vec_t;
  vec_t tv[6];

  logic [31:0] mem_m [logic [31:0]];
  bit ip, dp, dwe, in_txn, own_d, rd_wait, exp_d_ld, drain;
  logic [31:0] ia, da, dwd, ta, exp_i_rd, exp_d_rd;
  logic [3:0] dwm;
  int is, ds, rv_at, exp_i_c, exp_d_c, nready, nreq_i, nreq_d, nack_i, nack_d, nacks;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    i_req = 0; d_req = 0; d_we = 0; i_addr = 0; d_addr = 0; d_wdata = 0; d_wmask = 0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
  endtask

  task automatic do_reset();
    idle_in();
    reset = 0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1;
  endtask

  function automatic logic [31:0] rd_m(input logic [31:0] a);
    return mem_m.exists(a) ? mem_m[a] : a ^ 32'hA5A5_A5A5;
  endfunction

  function automatic void wr_m(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] o;
    o = rd_m(a);
    for (int b = 0; b < 4; b++) if (m[b]) o[8*b +: 8] = d[8*b +: 8];
    mem_m[a] = o;
  endfunction

  initial begin
    #500000;
    $display("FAIL sim_time_limit: got expired expected finish");
    $fatal(1);
  end

  initial begin
    tv[0] = '{1'b0, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 32'h0,    4'h0};
    tv[1] = '{1'b1, 1'b0, 1'b0, 4'hF, 1'b1, 1'b0, 32'h100,  4'h0};
    tv[2] = '{1'b0, 1'b1, 1'b0, 4'hF, 1'b1, 1'b0, 32'h2000, 4'h0};
    tv[3] = '{1'b0, 1'b1, 1'b1, 4'h3, 1'b1, 1'b1, 32'h2000, 4'h3};
    tv[4] = '{1'b1, 1'b1, 1'b1, 4'h3, 1'b1, 1'b1, 32'h2000, 4'h3};
    tv[5] = '{1'b1, 1'b1, 1'b0, 4'hF, 1'b1, 1'b0, 32'h2000, 4'h0};

    // outputs while reset is held
    idle_in();
    reset = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_acks", 32'({i_ack, d_ack}), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_we_wmask", 32'({mem_we, mem_wmask}), 0);
    chk("rst_rdata", i_rdata | d_rdata, 0);
    @(posedge clk);
    #1 reset = 1;

    // grant table: one IDLE cycle with the given requests, then inspect the issued op
    for (int k = 0; k < 6; k++) begin
      do_reset();
      i_req = tv[k].ir; d_req = tv[k].dr; d_we = tv[k].dw; d_wmask = tv[k].wm;
      i_addr = 32'h100; d_addr = 32'h2000; d_wdata = 32'h0BAD_F00D;
      adv();
      @(negedge clk);
      chk($sformatf("tv%0d_mem_req", k), 32'(mem_req), 32'(tv[k].er));
      if (tv[k].er) begin
        chk($sformatf("tv%0d_mem_we", k), 32'(mem_we), 32'(tv[k].ew));
        chk($sformatf("tv%0d_mem_addr", k), mem_addr, tv[k].ea);
        chk($sformatf("tv%0d_mem_wmask", k), 32'(mem_wmask), 32'(tv[k].ewm));
      end
    end

    // fetch only, 1-cycle read; rvalid in the accept cycle must be ignored
    do_reset();
    i_req = 1; i_addr = 32'h100; mem_ready = 1;
    @(negedge clk);
    chk("t1_c0_busy", 32'(busy), 0);
    adv();
    mem_rvalid = 1; mem_rdata = 32'hDEAD_DEAD;
    @(negedge clk);
    chk("t1_c1_mem_req", 32'(mem_req), 1);
    chk("t1_c1_mem_addr", mem_addr, 32'h100);
    chk("t1_c1_mem_we", 32'(mem_we), 0);
    adv();
    mem_rdata = 32'h0000_0013;
    @(negedge clk);
    chk("t1_c2_mem_req", 32'(mem_req), 0);
    chk("t1_c2_i_ack", 32'(i_ack), 0);
    adv();
    mem_rvalid = 0;
    @(negedge clk);
    chk("t1_c3_i_ack", 32'(i_ack), 1);
    chk("t1_c3_i_rdata", i_rdata, 32'h13);
    chk("t1_c3_busy", 32'(busy), 0);
    adv();
    i_req = 0;
    @(negedge clk);
    chk("t1_c4_i_ack", 32'(i_ack), 0);
    chk("t1_c4_no_regrant", 32'(busy), 0);

    // simultaneous store and fetch: store first, fetch right after its ack cycle
    do_reset();
    i_req = 1; i_addr = 32'h100; d_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'hCAFE_F00D;
    d_wmask = 4'b0011; mem_ready = 1;
    adv();
    @(negedge clk);
    chk("t2_st_req", 32'(mem_req), 1);
    chk("t2_st_we", 32'(mem_we), 1);
    chk("t2_st_addr", mem_addr, 32'h2000);
    chk("t2_st_wmask", 32'(mem_wmask), 32'h3);
    chk("t2_st_wdata", mem_wdata, 32'hCAFE_F00D);
    adv();
    @(negedge clk);
    chk("t2_d_ack", 32'(d_ack), 1);
    chk("t2_gap_req", 32'(mem_req), 0);
    adv();
    d_req = 0; mem_rvalid = 1; mem_rdata = 32'h7777;
    @(negedge clk);
    chk("t2_f_req", 32'(mem_req), 1);
    chk("t2_f_we", 32'(mem_we), 0);
    chk("t2_f_addr", mem_addr, 32'h100);
    chk("t2_f_wmask", 32'(mem_wmask), 0);
    chk("t2_d_ack_pulse", 32'(d_ack), 0);
    adv();
    mem_rdata = 32'h5555;
    @(negedge clk);
    chk("t2_resp_i_ack", 32'(i_ack), 0);
    adv();
    mem_rvalid = 0; i_req = 0;
    @(negedge clk);
    chk("t2_i_ack", 32'(i_ack), 1);
    chk("t2_i_rdata", i_rdata, 32'h5555);
    chk("t2_no_d_ack", 32'(d_ack), 0);

    // load under 5 cycles of back-pressure
    do_reset();
    d_req = 1; d_we = 0; d_addr = 32'h3000; d_wdata = 32'h1234; d_wmask = 4'hF;
    adv();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("t3_w%0d_req", k), 32'(mem_req), 1);
      chk($sformatf("t3_w%0d_addr", k), mem_addr, 32'h3000);
      chk($sformatf("t3_w%0d_we", k), 32'(mem_we), 0);
      chk($sformatf("t3_w%0d_wdata", k), mem_wdata, 32'h1234);
      chk($sformatf("t3_w%0d_ack", k), 32'(d_ack), 0);
      adv();
    end
    mem_ready = 1;
    @(negedge clk);
    chk("t3_accept_req", 32'(mem_req), 1);
    adv();
    mem_ready = 0;
    @(negedge clk);
    chk("t3_resp_busy", 32'(busy), 1);
    chk("t3_resp_ack", 32'(d_ack), 0);
    adv();
    mem_rvalid = 1; mem_rdata = 32'h0000_BEEF;
    adv();
    mem_rvalid = 0;
    @(negedge clk);
    chk("t3_d_ack", 32'(d_ack), 1);
    chk("t3_d_rdata", d_rdata, 32'hBEEF);
    adv();
    d_req = 0;
    @(negedge clk);
    chk("t3_single_ack", 32'(d_ack), 0);

    // watchdog on the TIMEOUT=4 instance: read accepted, rvalid never comes
    do_reset();
    i_req = 1; i_addr = 32'h180; mem_ready = 1;
    adv();
    adv();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("t4_resp%0d_busy", k), 32'(w1_busy), 1);
      chk($sformatf("t4_resp%0d_err", k), 32'(w1_err), 0);
      adv();
    end
    @(negedge clk);
    chk("t4_err_set", 32'(w1_err), 1);
    chk("t4_idle", 32'(w1_busy), 0);
    chk("t4_no_ack", 32'(w1_i_ack), 0);
    adv();
    i_req = 0;
    @(negedge clk);
    chk("t4_regrant", 32'(w1_mem_req), 1);
    nacks = 0;
    repeat (12) begin
      adv();
      @(negedge clk);
      if (w1_i_ack) nacks++;
    end
    chk("t4_acks_after", nacks, 0);
    chk("t4_err_sticky", 32'(w1_err), 1);
    chk("t4_final_idle", 32'(w1_busy), 0);
    do_reset();
    @(negedge clk);
    chk("t4_err_cleared", 32'(w1_err), 0);

    // asynchronous reset in the middle of a read response
    do_reset();
    d_req = 1; d_we = 0; d_addr = 32'h2040; i_req = 1; i_addr = 32'h140; mem_ready = 1;
    adv();
    adv();
    @(negedge clk);
    chk("t5_pre_busy", 32'(busy), 1);
    #2 reset = 0;
    #1;
    chk("t5_busy", 32'(busy), 0);
    chk("t5_mem_req", 32'(mem_req), 0);
    chk("t5_acks", 32'({i_ack, d_ack}), 0);
    @(posedge clk);
    #1 reset = 1;
    mem_ready = 0;
    adv();
    @(negedge clk);
    chk("t5_regrant_req", 32'(mem_req), 1);
    chk("t5_regrant_data", mem_addr, 32'h2040);

    // random traffic: bench plays both requesters and the memory
    do_reset();
    ip = 0; dp = 0; in_txn = 0; rd_wait = 0; exp_i_c = -1; exp_d_c = -1; nready = 0;
    nreq_i = 0; nreq_d = 0; nack_i = 0; nack_d = 0; ia = 0; da = 0; dwd = 0; dwm = 0; dwe = 0;
    ta = 0; own_d = 0; exp_d_ld = 0; is = 0; ds = 0; rv_at = 0;
    for (int c = 0; c < 3000; c++) begin
      drain = c >= 2500;
      if (!ip && !drain && $urandom_range(0, 2) == 0) begin
        ip = 1; is = c; ia = 32'h100 + 4 * $urandom_range(0, 7); nreq_i++;
      end
      if (!dp && !drain && $urandom_range(0, 2) == 0) begin
        dp = 1; ds = c; da = 32'h2000 + 4 * $urandom_range(0, 7); dwe = 1'($urandom_range(0, 1));
        dwd = $urandom; dwm = 4'($urandom_range(1, 15)); nreq_d++;
      end
      i_req = ip; i_addr = ia; d_req = dp; d_we = dwe; d_addr = da; d_wdata = dwd; d_wmask = dwm;
      mem_ready = (nready >= 3) || ($urandom_range(0, 2) != 0);
      nready = mem_ready ? 0 : nready + 1;
      if (rd_wait && c == rv_at) begin
        mem_rvalid = 1; mem_rdata = rd_m(ta);
      end else begin
        mem_rvalid = !rd_wait && $urandom_range(0, 3) == 0; mem_rdata = $urandom;
      end
      @(negedge clk);
      chk("rnd_i_ack", 32'(i_ack), 32'(exp_i_c == c));
      chk("rnd_d_ack", 32'(d_ack), 32'(exp_d_c == c));
      if (exp_i_c == c) chk("rnd_i_rdata", i_rdata, exp_i_rd);
      if (exp_d_c == c && exp_d_ld) chk("rnd_d_rdata", d_rdata, exp_d_rd);
      if (mem_req) begin
        if (!in_txn) begin
          in_txn = 1; own_d = mem_addr >= 32'h2000; ta = mem_addr;
          chk("rnd_grant_has_req", 32'(own_d ? (dp && ds < c) : (ip && is < c)), 1);
          if (!own_d) chk("rnd_data_priority", 32'(dp && ds < c), 0);
        end
        chk("rnd_one_outstanding", 32'(rd_wait || exp_i_c == c || exp_d_c == c), 0);
        chk("rnd_addr", mem_addr, own_d ? da : ia);
        chk("rnd_we", 32'(mem_we), 32'(own_d && dwe));
        chk("rnd_wmask", 32'(mem_wmask), 32'((own_d && dwe) ? dwm : 4'h0));
        if (own_d && dwe) chk("rnd_wdata", mem_wdata, dwd);
        if (mem_ready) begin
          if (own_d && dwe) begin
            wr_m(da, dwd, dwm); exp_d_c = c + 1; exp_d_ld = 0; in_txn = 0;
          end else begin
            rd_wait = 1; rv_at = c + $urandom_range(1, 4);
          end
        end
      end else if (rd_wait && c == rv_at) begin
        rd_wait = 0; in_txn = 0;
        if (own_d) begin
          exp_d_c = c + 1; exp_d_rd = rd_m(ta); exp_d_ld = 1;
        end else begin
          exp_i_c = c + 1; exp_i_rd = rd_m(ta);
        end
      end
      if (i_ack) begin ip = 0; nack_i++; end
      if (d_ack) begin dp = 0; nack_d++; end
      adv();
    end
    chk("rnd_fetch_drained", 32'(ip), 0);
    chk("rnd_data_drained", 32'(dp), 0);
    chk("rnd_fetch_ack_count", nack_i, nreq_i);
    chk("rnd_data_ack_count", nack_d, nreq_d);
    chk("rnd_no_err", 32'(err), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
